// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a byte FIFO, LSB-first framing, optional parity and 1/2 stop bits.
// Line changes only on rising edges of baud_clk as seen in the clk domain.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baud_clk,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               r_state, w_state;
  logic                 r_baud_q, w_tick, w_push, w_pop, w_have, w_last_stop;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] r_shift, w_shift, w_head;
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic [3:0]           r_bit_cnt, w_bit_cnt;
  logic                 r_stop_cnt, w_stop_cnt;
  logic                 r_par, w_par, r_tx, w_tx;
  // baud_q resets high so a level already high at reset release is not an edge
  assign w_tick      = baud_clk & ~r_baud_q;
  assign w_have      = r_count != '0;
  assign w_head      = r_mem[r_rptr];
  assign w_last_stop = (STOP_BITS == 1) | r_stop_cnt;
  assign tx_ready    = r_count != CW'(FIFO_DEPTH);
  assign w_push      = tx_valid & tx_ready;
  assign tx_out      = r_tx;
  assign busy        = (r_state != IDLE) | w_have;
  assign fifo_count  = r_count;
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_par      = r_par;
    w_tx       = r_tx;
    w_pop      = 1'b0;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          w_pop   = w_have;
          w_tx    = ~w_have;
          w_state = w_have ? START : IDLE;
        end
        START: begin
          w_tx      = r_shift[0];
          w_bit_cnt = '0;
          w_state   = DATA;
        end
        DATA: begin
          w_shift   = r_shift >> 1;
          w_bit_cnt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
            w_tx       = (PARITY_EN != 0) ? r_par : 1'b1;
            w_state    = (PARITY_EN != 0) ? PARITY : STOP;
            w_stop_cnt = 1'b0;
          end else begin
            w_tx = r_shift[1];
          end
        end
        PARITY: begin
          w_tx       = 1'b1;
          w_state    = STOP;
          w_stop_cnt = 1'b0;
        end
        STOP: begin
          if (w_last_stop) begin
            w_pop   = w_have;
            w_tx    = ~w_have;
            w_state = w_have ? START : IDLE;
          end else begin
            w_stop_cnt = 1'b1;
          end
        end
        default: w_state = IDLE;
      endcase
    end
    if (w_pop) begin
      w_shift = w_head;
      w_par   = ^w_head ^ 1'(PARITY_ODD);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_baud_q   <= 1'b1;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tx       <= w_tx;
      r_baud_q   <= baud_clk;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_par      <= w_par;
      r_wptr     <= w_push ? r_wptr + 1'b1 : r_wptr;
      r_rptr     <= w_pop ? r_rptr + 1'b1 : r_rptr;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end
endmodule
